// File: rtl/tetris_board_store.sv
// tetris_board_store: board-cell storage for a Tetris game.
//  - Display path queries pos -> colour every clock (latency 1).
//  - Game engine writes cells while IDLE and starts line-clear passes.
//  - A line-clear pass scans rows bottom-up and shifts the board down one
//    row per cycle over every full row it finds.
// Optional feature macro: TETRIS_BOARD_PROBE_EN adds a registered occupancy
// probe (probe_pos -> probe_hit) for collision checks; walls/floor read as hit.
module tetris_board_store #(
  parameter int NUM_X  = 10,
  parameter int NUM_Y  = 20,
  parameter int CELL_W = 3,
  parameter int POS_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [POS_W-1:0]  query_pos,
  output logic [CELL_W-1:0] query_res,
  input  logic              wr_en,
  input  logic [POS_W-1:0]  wr_pos,
  input  logic [CELL_W-1:0] wr_color,
  output logic              wr_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [4:0]        lines_cleared
`ifdef TETRIS_BOARD_PROBE_EN
  ,
  input  logic [POS_W-1:0]  probe_pos,
  output logic              probe_hit
`endif
);

  localparam int               L_N     = NUM_X * NUM_Y;
  localparam int               K_W     = $clog2(NUM_Y);
  localparam logic [POS_W-1:0] L_TOTAL = POS_W'(L_N);
  localparam logic [K_W-1:0]   L_TOP   = K_W'(NUM_Y - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  logic [K_W-1:0]    r_row;      // row under scan
  logic [K_W-1:0]    r_k;        // row being overwritten during a shift
  logic              r_busy;
  logic              r_ready;
  logic              r_done;
  logic [4:0]        r_lines;
  logic [CELL_W-1:0] r_query_res;
  logic [CELL_W-1:0] r_cells [L_N];
  logic              w_row_full;

  // Full-row detect for the row currently selected by r_row.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    w_row_full = 1'b1;
    for (int i = 0; i < NUM_Y; i++) begin
      for (int j = 0; j < NUM_X; j++) begin
        if (r_row == K_W'(i) && r_cells[i*NUM_X+j] == '0) w_row_full = 1'b0;
      end
    end
  end

  // Cell array: engine writes in IDLE, one-row downward shift in SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the board must read empty right after reset, so every cell is a
      // resettable flop rather than an uninitialised RAM.
      for (int i = 0; i < L_N; i++) r_cells[i] <= '0;
    end else if (r_state == S_IDLE) begin
      if (wr_en && wr_pos < L_TOTAL) r_cells[wr_pos] <= wr_color;
    end else if (r_state == S_SHIFT) begin
      for (int i = 0; i < NUM_Y - 1; i++) begin
        if (r_k == K_W'(i)) begin
          for (int j = 0; j < NUM_X; j++) r_cells[i*NUM_X+j] <= r_cells[(i+1)*NUM_X+j];
        end
      end
      if (r_k == L_TOP) begin
        for (int j = 0; j < NUM_X; j++) r_cells[(NUM_Y-1)*NUM_X+j] <= '0;
      end
    end
  end

  // Display query: registered read of the live board, zero when off-board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_query_res <= '0;
    end else if (query_pos < L_TOTAL) begin
      r_query_res <= r_cells[query_pos];
    end else begin
      r_query_res <= '0;
    end
  end

  // Line-clear FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_lines <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state <= S_SCAN;
            r_row   <= '0;
            r_lines <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_row_full) begin
            r_state <= S_SHIFT;
            r_k     <= r_row;
            if (r_lines != 5'd31) r_lines <= r_lines + 5'd1;
          end else if (r_row == L_TOP) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_row <= r_row + K_W'(1);
          end
        end
        S_SHIFT: begin
          // Return to the same row: whatever dropped into it may be full too.
          if (r_k == L_TOP) r_state <= S_SCAN;
          else              r_k     <= r_k + K_W'(1);
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TETRIS_BOARD_PROBE_EN
  logic r_probe_hit;

  // Occupancy probe: off-board positions count as occupied (walls/floor).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_probe_hit <= 1'b0;
    else if (probe_pos < L_TOTAL) r_probe_hit <= (r_cells[probe_pos] != '0);
    else                          r_probe_hit <= 1'b1;
  end

  assign probe_hit = r_probe_hit;
`endif

  assign query_res     = r_query_res;
  assign wr_ready      = r_ready;
  assign clear_busy    = r_busy;
  assign clear_done    = r_done;
  assign lines_cleared = r_lines;

endmodule

// File: tb/tb_tetris_board_store.sv
// Self-checking bench for tetris_board_store: a reference board model,
// a query scoreboard, and directed line-clear scenarios.
module tb_tetris_board_store;

  localparam int NX = 10;
  localparam int NY = 20;
  localparam int N  = NX * NY;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] query_pos = '0;
  logic [2:0] query_res;
  logic       wr_en = 1'b0;
  logic [7:0] wr_pos = '0;
  logic [2:0] wr_color = '0;
  logic       wr_ready;
  logic       clear_req = 1'b0;
  logic       clear_busy;
  logic       clear_done;
  logic [4:0] lines_cleared;
`ifdef TETRIS_BOARD_PROBE_EN
  logic [7:0] probe_pos = '0;
  logic       probe_hit;
`endif

  tetris_board_store dut (
    .clk           (clk),
    .reset         (reset),
    .query_pos     (query_pos),
    .query_res     (query_res),
    .wr_en         (wr_en),
    .wr_pos        (wr_pos),
    .wr_color      (wr_color),
    .wr_ready      (wr_ready),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .lines_cleared (lines_cleared)
`ifdef TETRIS_BOARD_PROBE_EN
    ,
    .probe_pos     (probe_pos),
    .probe_hit     (probe_hit)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int exp;
  } sb_item_t;

  sb_item_t   sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] m [N];
  int         exp_lines = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the edge and retire any pending query.
  task automatic tick();
    sb_item_t it;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      check($sformatf("query[%0d]", it.pos), 32'(query_res), it.exp);
    end
  endtask

  task automatic query(input int pos);
    sb_item_t it;
    query_pos = 8'(pos);
    it.pos = pos;
    it.exp = (pos < N) ? int'(m[pos]) : 0;
    sb.push_back(it);
    tick();
  endtask

  task automatic sweep();
    for (int p = 0; p < N; p++) query(p);
  endtask

  task automatic write(input int pos, input int color);
    wr_en    = 1'b1;
    wr_pos   = 8'(pos);
    wr_color = 3'(color);
    tick();
    wr_en = 1'b0;
    if (pos < N) m[pos] = 3'(color);
  endtask

  task automatic fill_row(input int y, input int color);
    for (int x = 0; x < NX; x++) write(y*NX + x, color);
  endtask

  // Reference line clear: keep non-full rows in order, compacted downwards.
  task automatic model_clear(output int n);
    logic [2:0] t [N];
    int         out_row;
    bit         full;
    n = 0;
    out_row = 0;
    for (int i = 0; i < N; i++) t[i] = '0;
    for (int y = 0; y < NY; y++) begin
      full = 1'b1;
      for (int x = 0; x < NX; x++) if (m[y*NX+x] == 0) full = 1'b0;
      if (full) n++;
      else begin
        for (int x = 0; x < NX; x++) t[out_row*NX+x] = m[y*NX+x];
        out_row++;
      end
    end
    for (int i = 0; i < N; i++) m[i] = t[i];
  endtask

  // Run one pass; optionally inject a dropped write and a second clear_req.
  task automatic run_clear(input string tag, input int max_cycles, input bit inject);
    int dones;
    int cyc;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check({tag, "_busy_start"}, 32'(clear_busy), 1);
    check({tag, "_ready_start"}, 32'(wr_ready), 0);
    dones = 0;
    cyc   = 1;
    while (clear_busy === 1'b1 && cyc < max_cycles) begin
      if (clear_done === 1'b1) dones++;
      if (inject && cyc == 3) begin
        wr_en     = 1'b1;
        wr_pos    = 8'd50;
        wr_color  = 3'd7;
        clear_req = 1'b1;
      end
      tick();
      if (inject && cyc == 3) begin
        wr_en     = 1'b0;
        clear_req = 1'b0;
      end
      cyc++;
    end
    model_clear(exp_lines);
    check({tag, "_ended"}, 32'(clear_busy), 0);
    check({tag, "_within_bound"}, 32'(cyc <= max_cycles), 1);
    check({tag, "_done_pulses"}, 32'(dones), 1);
    check({tag, "_done_low_after"}, 32'(clear_done), 0);
    check({tag, "_lines"}, 32'(lines_cleared), 32'(exp_lines));
    check({tag, "_ready_after"}, 32'(wr_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) m[i] = '0;

    // Reset values while reset is held low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_query_res", 32'(query_res), 0);
    check("rst_busy", 32'(clear_busy), 0);
    check("rst_ready", 32'(wr_ready), 1);
    check("rst_done", 32'(clear_done), 0);
    check("rst_lines", 32'(lines_cleared), 0);
`ifdef TETRIS_BOARD_PROBE_EN
    check("rst_probe_hit", 32'(probe_hit), 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // 1: empty board everywhere.
    sweep();
    check("t1_busy", 32'(clear_busy), 0);
    check("t1_ready", 32'(wr_ready), 1);

    // 2: single write, in-range and off-board queries.
    write(5, 3);
    query(5);
    query(200);
    query(255);
    // Same-cycle write and query of one cell returns the old contents.
    wr_en = 1'b1; wr_pos = 8'd7; wr_color = 3'd5;
    query_pos = 8'd7;
    tick();
    check("t2_rw_same_cycle_old", 32'(query_res), 0);
    wr_en = 1'b0;
    m[7] = 3'd5;
    query(7);
    write(230, 6);            // off-board write is ignored
    query(5);

    // 3: one full bottom row with a cell above it.
    for (int i = 0; i < N; i++) begin
      if (m[i] != 0) write(i, 0);
    end
    fill_row(0, 1);
    write(10, 2);
    run_clear("t3", 442, 1'b0);
    check("t3_lines_is_1", 32'(lines_cleared), 1);
    sweep();

    // 4: two full rows, then a lone cell dropped to the floor.
    fill_row(0, 5);
    fill_row(1, 6);
    write(20, 4);
    run_clear("t4", 422, 1'b0);
    check("t4_lines_is_2", 32'(lines_cleared), 2);
    query(0);
    sweep();

    // 5: writes and clear requests during a pass are dropped.
    fill_row(0, 2);
    write(15, 3);
    run_clear("t5", 442, 1'b1);
    query(50);
    sweep();
    write(60, 1);
    check("t5_lines_hold", 32'(lines_cleared), 32'(exp_lines));

`ifdef TETRIS_BOARD_PROBE_EN
    probe_pos = 8'd200;
    tick();
    check("probe_offboard", 32'(probe_hit), 1);
    probe_pos = 8'd199;
    tick();
    check("probe_empty", 32'(probe_hit), 0);
    probe_pos = 8'd60;
    tick();
    check("probe_occupied", 32'(probe_hit), 1);
`endif

    // 6: reset mid-shift aborts the pass and empties the board.
    fill_row(0, 3);
    fill_row(1, 4);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    check("t6_busy_before_reset", 32'(clear_busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_busy_async", 32'(clear_busy), 0);
    check("t6_ready_async", 32'(wr_ready), 1);
    check("t6_done_async", 32'(clear_done), 0);
    check("t6_lines_async", 32'(lines_cleared), 0);
    check("t6_query_async", 32'(query_res), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_done_in_reset", 32'(clear_done), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_done_after", 32'(clear_done), 0);
    end
    sweep();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
